// File: rtl/pbit_pkg.sv
// Shared constants and datapath types for the p-bit sampler.
package pbit_pkg;

    localparam int NOISE_W          = 16;
    localparam int SUM_W            = 18;
    localparam int X_MAX            = 32768;
    localparam int IW_DEFAULT       = 8;
    localparam int WIN_LOG2_DEFAULT = 8;

    // x needs one bit more than the noise so that +32768 is representable.
    localparam int X_W = NOISE_W + 1;

    typedef logic signed [X_W-1:0]     x_t;
    typedef logic signed [NOISE_W-1:0] noise_t;
    typedef logic signed [SUM_W-1:0]   sum_t;

endpackage

// File: rtl/pbit_window_counter.sv
// Counts m=1 samples over fixed windows of 2^WIN_LOG2 valid samples.
module pbit_window_counter
    import pbit_pkg::*;
#(
    parameter int WIN_LOG2 = WIN_LOG2_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                sample_valid,
    input  logic                sample_bit,
    output logic [WIN_LOG2:0]   count_out,
    output logic                count_valid
);

    logic [WIN_LOG2-1:0] idx;
    logic [WIN_LOG2:0]   run;
    logic [WIN_LOG2:0]   run_next;
    logic                last;

    // run is one bit wider than idx so an all-ones window reaches 2^WIN_LOG2.
    assign run_next = run + {{WIN_LOG2{1'b0}}, sample_bit};
    assign last     = (idx == {WIN_LOG2{1'b1}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            run         <= '0;
            count_out   <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (clear) begin
                idx <= '0;
                run <= '0;
            end else if (sample_valid) begin
                if (last) begin
                    count_out   <= run_next;
                    count_valid <= 1'b1;
                    idx         <= '0;
                    run         <= '0;
                end else begin
                    idx <= idx + WIN_LOG2'(1);
                    run <= run_next;
                end
            end
        end
    end

endmodule

// File: rtl/pbit_sampler.sv
// Probabilistic bit: m = 1 with probability clamp((x+32768)/65536), x = i_in << beta.
module pbit_sampler
    import pbit_pkg::*;
#(
    parameter int IW       = IW_DEFAULT,
    parameter int WIN_LOG2 = WIN_LOG2_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] i_in,
    input  logic [3:0]           beta,
    input  logic [31:0]          rnd,
    output logic                 m,
    output logic                 m_valid,
    output logic [WIN_LOG2:0]    count_out,
    output logic                 count_valid
);

    localparam int WIDE_W = IW + 16;
    localparam logic signed [WIDE_W-1:0] WIDE_HI = WIDE_W'(X_MAX);
    localparam logic signed [WIDE_W-1:0] WIDE_LO = -WIDE_HI;
    localparam x_t   X_HI     = x_t'(X_MAX);
    localparam x_t   X_LO     = -X_HI;
    localparam sum_t SUM_ZERO = '0;

    function automatic x_t sat_shift(input logic signed [IW-1:0] v, input logic [3:0] sh);
        logic signed [WIDE_W-1:0] wide;
        wide = {{16{v[IW-1]}}, v};
        wide = wide <<< sh;
        if (wide > WIDE_HI)
            return X_HI;
        else if (wide < WIDE_LO)
            return X_LO;
        else
            return x_t'(wide);
    endfunction

    function automatic logic decide(input x_t x, input noise_t n);
        sum_t sum;
        sum = sum_t'(x) + sum_t'(n);
        return (sum >= SUM_ZERO);
    endfunction

    x_t     x_p1;
    noise_t noise_p1;
    logic   vld_p1;
    logic   vld_p2;

    // Only the top half of the random word is used as noise.
    logic unused_rnd_lo;
    assign unused_rnd_lo = ^rnd[15:0];

    // Stage 1: scale and saturate the input current, capture the noise word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= in_valid && !clear;
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            x_p1     <= sat_shift(i_in, beta);
            noise_p1 <= noise_t'(rnd[31:16]);
        end
    end

    // Stage 2: threshold x + noise; m holds whenever no sample arrives
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2 <= 1'b0;
            m      <= 1'b0;
        end else begin
            vld_p2 <= vld_p1 && !clear;
            if (vld_p1 && !clear)
                m <= decide(x_p1, noise_p1);
        end
    end

    assign m_valid = vld_p2;

    pbit_window_counter #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_window (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .sample_valid (vld_p2),
        .sample_bit   (m),
        .count_out    (count_out),
        .count_valid  (count_valid)
    );

endmodule
